// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states,
// datapath mux selects and the bundle of control outputs.
package multicycle_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_EXEC_R    = 4'd2,
      ST_EXEC_I    = 4'd3,
      ST_ALU_WB    = 4'd4,
      ST_MEM_ADDR  = 4'd5,
      ST_MEM_RD    = 4'd6,
      ST_MEM_WB    = 4'd7,
      ST_MEM_WR    = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JALR_EXEC = 4'd10,
      ST_JUMP      = 4'd11,
      ST_UPPER_WB  = 4'd12,
      ST_TRAP      = 4'd13
   } state_e;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;
   localparam logic [1:0] WB_IMM    = 2'b11;

   localparam logic [1:0] A_PC     = 2'b00;
   localparam logic [1:0] A_OLD_PC = 2'b01;
   localparam logic [1:0] A_RS1    = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_FOUR = 2'b01;
   localparam logic [1:0] B_IMM  = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_RTYPE = 2'b10;
   localparam logic [1:0] ALU_ITYPE = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic [1:0] wb_sel;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluop;
      logic       pc_src;
   } ctrl_t;

   function automatic logic is_mem_wait(input state_e s);
      return s inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles in a memory state
// and flags the cycle where the count reaches MEM_TIMEOUT without mem_ready.
module mc_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_wait,
   input  logic mem_ready,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Count is held at zero outside memory states, so every entry starts from 0.
   always_comb begin
      // NOTE: default assignment first keeps count_d driven on every path, so no latch.
      count_d = '0;
      if (in_wait && !mem_ready) count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for flops so all registers update from pre-edge values.
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign expired = in_wait && !mem_ready && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: one state per clock through fetch, decode,
// execute, memory and writeback, with sticky illegal/timeout traps.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter bit          SUPPORT_JUMP  = 1'b1,
   parameter bit          SUPPORT_UPPER = 1'b1,
   parameter int unsigned MEM_TIMEOUT   = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       regwrite,
   output logic [1:0] wb_sel,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] aluop,
   output logic       pc_src,
   output logic       illegal,
   output logic       timeout,
   output logic [3:0] state_dbg
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   timeout_q, timeout_d;
   logic   in_wait, expired;
   ctrl_t  ctrl, ctrl_out;

   assign in_wait = is_mem_wait(state_q);

   mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_wait   (in_wait),
      .mem_ready (mem_ready),
      .expired   (expired)
   );

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready)    state_d = ST_DECODE;
            else if (expired) begin state_d = ST_TRAP; timeout_d = 1'b1; end
         end
         ST_DECODE: begin
            case (opcode)
               OP_R:                state_d = ST_EXEC_R;
               OP_I:                state_d = ST_EXEC_I;
               OP_LOAD, OP_STORE:   state_d = ST_MEM_ADDR;
               OP_BRANCH:           state_d = ST_BRANCH;
               OP_JAL:   if (SUPPORT_JUMP)  state_d = ST_JUMP;      else state_d = ST_TRAP;
               OP_JALR:  if (SUPPORT_JUMP)  state_d = ST_JALR_EXEC; else state_d = ST_TRAP;
               OP_LUI:   if (SUPPORT_UPPER) state_d = ST_UPPER_WB;  else state_d = ST_TRAP;
               OP_AUIPC: if (SUPPORT_UPPER) state_d = ST_ALU_WB;    else state_d = ST_TRAP;
               default:             state_d = ST_TRAP;
            endcase
            if (state_d == ST_TRAP) illegal_d = 1'b1;
         end
         ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
         ST_MEM_ADDR: begin
            if (opcode == OP_LOAD) state_d = ST_MEM_RD;
            else                   state_d = ST_MEM_WR;
         end
         ST_MEM_RD: begin
            if (mem_ready)    state_d = ST_MEM_WB;
            else if (expired) begin state_d = ST_TRAP; timeout_d = 1'b1; end
         end
         ST_MEM_WR: begin
            if (mem_ready)    state_d = ST_FETCH;
            else if (expired) begin state_d = ST_TRAP; timeout_d = 1'b1; end
         end
         ST_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) state_d = ST_FETCH;
            else begin state_d = ST_TRAP; illegal_d = 1'b1; end
         end
         ST_JALR_EXEC: state_d = ST_JUMP;
         ST_ALU_WB, ST_MEM_WB, ST_JUMP, ST_UPPER_WB: state_d = ST_FETCH;
         ST_TRAP:  state_d = ST_TRAP;
         default:  state_d = ST_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // Moore decode of the state; only FETCH (mem_ready) and BRANCH (zero) look at inputs.
   always_comb begin
      ctrl = '0;
      case (state_q)
         ST_FETCH: begin
            ctrl.memread   = 1'b1;
            ctrl.alu_src_a = A_PC;
            ctrl.alu_src_b = B_FOUR;
            ctrl.aluop     = ALU_ADD;
            if (mem_ready) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
            end
         end
         ST_DECODE: begin
            ctrl.alu_src_a = A_OLD_PC;
            ctrl.alu_src_b = B_IMM;
            ctrl.aluop     = ALU_ADD;
         end
         ST_EXEC_R: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_RS2;
            ctrl.aluop     = ALU_RTYPE;
         end
         ST_EXEC_I: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_IMM;
            ctrl.aluop     = ALU_ITYPE;
         end
         ST_MEM_ADDR, ST_JALR_EXEC: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_IMM;
            ctrl.aluop     = ALU_ADD;
         end
         ST_ALU_WB:   begin ctrl.regwrite = 1'b1; ctrl.wb_sel = WB_ALUOUT; end
         ST_MEM_RD:   begin ctrl.iord = 1'b1; ctrl.memread = 1'b1; end
         ST_MEM_WB:   begin ctrl.regwrite = 1'b1; ctrl.wb_sel = WB_MDR; end
         ST_MEM_WR:   begin ctrl.iord = 1'b1; ctrl.memwrite = 1'b1; end
         ST_BRANCH: begin
            ctrl.alu_src_a = A_RS1;
            ctrl.alu_src_b = B_RS2;
            ctrl.aluop     = ALU_SUB;
            ctrl.pc_src    = 1'b1;
            ctrl.pc_write  = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
         end
         ST_JUMP: begin
            ctrl.regwrite = 1'b1;
            ctrl.wb_sel   = WB_PC;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = 1'b1;
         end
         ST_UPPER_WB: begin ctrl.regwrite = 1'b1; ctrl.wb_sel = WB_IMM; end
         default: ctrl = '0;
      endcase
   end

   // Holding rst_n low silences every output, including the cycle that abandons an instruction.
   assign ctrl_out  = rst_n ? ctrl : '0;
   assign pc_write  = ctrl_out.pc_write;
   assign ir_write  = ctrl_out.ir_write;
   assign iord      = ctrl_out.iord;
   assign memread   = ctrl_out.memread;
   assign memwrite  = ctrl_out.memwrite;
   assign regwrite  = ctrl_out.regwrite;
   assign wb_sel    = ctrl_out.wb_sel;
   assign alu_src_a = ctrl_out.alu_src_a;
   assign alu_src_b = ctrl_out.alu_src_b;
   assign aluop     = ctrl_out.aluop;
   assign pc_src    = ctrl_out.pc_src;
   assign illegal   = rst_n & illegal_q;
   assign timeout   = rst_n & timeout_q;
   assign state_dbg = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: u has jumps/upper enabled with MEM_TIMEOUT=3,
// v has both disabled with the default MEM_TIMEOUT=15; both share the same stimulus.
module tb_multicycle_control;
   import multicycle_pkg::*;

   logic       clk, rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero, mem_ready;

   logic       u_pc_write, u_ir_write, u_iord, u_memread, u_memwrite, u_regwrite, u_pc_src;
   logic [1:0] u_wb_sel, u_alu_src_a, u_alu_src_b, u_aluop;
   logic       u_illegal, u_timeout;
   logic [3:0] u_state_dbg;

   logic       v_pc_write, v_ir_write, v_iord, v_memread, v_memwrite, v_regwrite, v_pc_src;
   logic [1:0] v_wb_sel, v_alu_src_a, v_alu_src_b, v_aluop;
   logic       v_illegal, v_timeout;
   logic [3:0] v_state_dbg;

   logic [14:0] u_ctrl;
   assign u_ctrl = {u_pc_write, u_ir_write, u_iord, u_memread, u_memwrite, u_regwrite,
                    u_wb_sel, u_alu_src_a, u_alu_src_b, u_aluop, u_pc_src};

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_control #(.SUPPORT_JUMP(1'b1), .SUPPORT_UPPER(1'b1), .MEM_TIMEOUT(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .pc_write(u_pc_write), .ir_write(u_ir_write), .iord(u_iord),
      .memread(u_memread), .memwrite(u_memwrite), .regwrite(u_regwrite), .wb_sel(u_wb_sel),
      .alu_src_a(u_alu_src_a), .alu_src_b(u_alu_src_b), .aluop(u_aluop), .pc_src(u_pc_src),
      .illegal(u_illegal), .timeout(u_timeout), .state_dbg(u_state_dbg)
   );

   multicycle_control #(.SUPPORT_JUMP(1'b0), .SUPPORT_UPPER(1'b0), .MEM_TIMEOUT(15)) v_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .pc_write(v_pc_write), .ir_write(v_ir_write), .iord(v_iord),
      .memread(v_memread), .memwrite(v_memwrite), .regwrite(v_regwrite), .wb_sel(v_wb_sel),
      .alu_src_a(v_alu_src_a), .alu_src_b(v_alu_src_b), .aluop(v_aluop), .pc_src(v_pc_src),
      .illegal(v_illegal), .timeout(v_timeout), .state_dbg(v_state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Packs hand-written expected control values in the same order as u_ctrl.
   function automatic logic [14:0] cv(input logic pcw, input logic irw, input logic io,
                                      input logic mrd, input logic mwr, input logic rw,
                                      input logic [1:0] wb, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op,
                                      input logic pcs);
      return {pcw, irw, io, mrd, mwr, rw, wb, a, b, op, pcs};
   endfunction

   // Drive inputs just after an edge, check mid-cycle, then advance one clock.
   task automatic step(input string tag, input logic mr, input logic z,
                       input state_e st, input logic [14:0] c);
      mem_ready = mr;
      zero      = z;
      #1;
      check({tag, ".state"}, 32'(u_state_dbg), 32'(st));
      check({tag, ".ctrl"},  32'(u_ctrl),      32'(c));
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      #1;
      check({tag, ".ctrl_low"},  32'(u_ctrl),      32'd0);
      check({tag, ".state_low"}, 32'(u_state_dbg), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check({tag, ".illegal"}, 32'(u_illegal), 32'd0);
      check({tag, ".timeout"}, 32'(u_timeout), 32'd0);
   endtask

   initial begin
      logic [14:0] f_rdy, f_wait, dec;
      f_rdy  = cv(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
      f_wait = cv(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
      dec    = cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);

      rst_n = 1'b0; opcode = OP_R; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      do_reset("rst0");

      opcode = OP_R;
      step("add.c1", 1, 0, ST_FETCH,  f_rdy);
      step("add.c2", 1, 0, ST_DECODE, dec);
      step("add.c3", 1, 0, ST_EXEC_R, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
      step("add.c4", 1, 0, ST_ALU_WB, cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));

      opcode = OP_LOAD;
      step("lw.c1", 1, 0, ST_FETCH,    f_rdy);
      step("lw.c2", 1, 0, ST_DECODE,   dec);
      step("lw.c3", 1, 0, ST_MEM_ADDR, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
      step("lw.c4", 0, 0, ST_MEM_RD,   cv(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      step("lw.c5", 0, 0, ST_MEM_RD,   cv(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      step("lw.c6", 1, 0, ST_MEM_RD,   cv(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      step("lw.c7", 1, 0, ST_MEM_WB,   cv(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0));

      opcode = OP_STORE;
      step("sw.c1", 1, 0, ST_FETCH,    f_rdy);
      step("sw.c2", 1, 0, ST_DECODE,   dec);
      step("sw.c3", 1, 0, ST_MEM_ADDR, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
      step("sw.c4", 1, 0, ST_MEM_WR,   cv(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

      opcode = OP_BRANCH; funct3 = 3'b000;
      step("beq.c1", 1, 1, ST_FETCH,  f_rdy);
      step("beq.c2", 1, 1, ST_DECODE, dec);
      step("beq.c3", 1, 1, ST_BRANCH, cv(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1));
      funct3 = 3'b001;
      step("bne.c1", 1, 1, ST_FETCH,  f_rdy);
      step("bne.c2", 1, 1, ST_DECODE, dec);
      step("bne.c3", 1, 1, ST_BRANCH, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1));
      funct3 = 3'b010;
      step("bad.c1", 1, 0, ST_FETCH,  f_rdy);
      step("bad.c2", 1, 0, ST_DECODE, dec);
      step("bad.c3", 1, 0, ST_BRANCH, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1));
      step("bad.trap1", 1, 0, ST_TRAP, 15'd0);
      step("bad.trap2", 1, 0, ST_TRAP, 15'd0);
      check("bad.illegal", 32'(u_illegal), 32'd1);
      check("bad.timeout", 32'(u_timeout), 32'd0);
      funct3 = 3'b000;
      do_reset("rst1");

      opcode = OP_JAL;
      step("jal.c1", 1, 0, ST_FETCH,  f_rdy);
      step("jal.c2", 1, 0, ST_DECODE, dec);
      step("jal.c3", 1, 0, ST_JUMP,   cv(1, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 1));
      check("jal.nojump.state",   32'(v_state_dbg), 32'(ST_TRAP));
      check("jal.nojump.illegal", 32'(v_illegal),   32'd1);

      opcode = OP_JALR;
      step("jalr.c1", 1, 0, ST_FETCH,     f_rdy);
      step("jalr.c2", 1, 0, ST_DECODE,    dec);
      step("jalr.c3", 1, 0, ST_JALR_EXEC, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
      step("jalr.c4", 1, 0, ST_JUMP,      cv(1, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 1));

      opcode = OP_LUI;
      step("lui.c1", 1, 0, ST_FETCH,    f_rdy);
      step("lui.c2", 1, 0, ST_DECODE,   dec);
      step("lui.c3", 1, 0, ST_UPPER_WB, cv(0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0));

      opcode = OP_AUIPC;
      step("auipc.c1", 1, 0, ST_FETCH,  f_rdy);
      step("auipc.c2", 1, 0, ST_DECODE, dec);
      step("auipc.c3", 1, 0, ST_ALU_WB, cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      check("auipc.u_illegal", 32'(u_illegal), 32'd0);

      // Reset lands on the ALU_WB cycle; regwrite must stay low there.
      opcode = OP_R;
      step("mid.c1", 1, 0, ST_FETCH,  f_rdy);
      step("mid.c2", 1, 0, ST_DECODE, dec);
      step("mid.c3", 1, 0, ST_EXEC_R, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
      do_reset("mid.rst");
      check("mid.state", 32'(u_state_dbg), 32'(ST_FETCH));

      // mem_ready stuck low in FETCH: u traps after 4 cycles, v after 16.
      for (int i = 0; i < 16; i++) begin
         mem_ready = 1'b0;
         #1;
         check($sformatf("to.v.fetch%0d", i), 32'(v_state_dbg), 32'(ST_FETCH));
         if (i < 4) begin
            check($sformatf("to.u.fetch%0d", i), 32'(u_state_dbg), 32'(ST_FETCH));
            check($sformatf("to.u.ctrl%0d", i),  32'(u_ctrl),      32'(f_wait));
         end else begin
            check($sformatf("to.u.trap%0d", i),  32'(u_state_dbg), 32'(ST_TRAP));
            check($sformatf("to.u.ctrl%0d", i),  32'(u_ctrl),      32'd0);
         end
         @(posedge clk); #1;
      end
      check("to.v.state",   32'(v_state_dbg), 32'(ST_TRAP));
      check("to.v.timeout", 32'(v_timeout),   32'd1);
      check("to.u.timeout", 32'(u_timeout),   32'd1);
      check("to.u.illegal", 32'(u_illegal),   32'd0);
      do_reset("to.rst");
      check("to.rst.state",  32'(u_state_dbg), 32'(ST_FETCH));
      check("to.rst.v_time", 32'(v_timeout),   32'd0);

      // mem_ready arrives on the cycle the count equals the limit: normal advance.
      opcode = OP_R;
      step("race.w0", 0, 0, ST_FETCH, f_wait);
      step("race.w1", 0, 0, ST_FETCH, f_wait);
      step("race.w2", 0, 0, ST_FETCH, f_wait);
      step("race.rdy", 1, 0, ST_FETCH, f_rdy);
      check("race.timeout", 32'(u_timeout), 32'd0);
      step("race.dec", 1, 0, ST_DECODE, dec);
      step("race.ex",  1, 0, ST_EXEC_R, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
      step("race.wb",  1, 0, ST_ALU_WB, cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      step("race.next", 1, 0, ST_FETCH, f_rdy);
      check("race.timeout_end", 32'(u_timeout), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
